// File: rtl/div_sched.sv
// Divide/modulo sequencer for the B-pipe: holds IF..EX while a 32-step radix-2
// restoring divide runs, then presents the quotient or remainder to MEM.
module div_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        EX_div_valid,
   input  logic [1:0]  EX_div_op,
   input  logic [31:0] EX_div_src1,
   input  logic [31:0] EX_div_src2,
   input  logic        flush,
   input  logic        stall_dcache,
   output logic        stall_div,
   output logic [31:0] MEM_div_result,
   output logic        div_done
);

   typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic [31:0] rem_q;
   logic        neg_quo_q;
   logic        neg_rem_q;
   logic        rem_sel_q;

   logic        accept;
   logic        is_signed;
   logic        src1_neg;
   logic        src2_neg;
   logic [31:0] abs1;
   logic [31:0] abs2;
   logic [32:0] diff;
   logic [31:0] restore;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign accept    = (state_q == StIdle) & EX_div_valid & !flush;
   assign is_signed = !EX_div_op[0];
   assign src1_neg  = is_signed & EX_div_src1[31];
   assign src2_neg  = is_signed & EX_div_src2[31];
   // Magnitudes wrap at 32 bits, so 0x80000000 stays 0x80000000.
   assign abs1      = src1_neg ? -EX_div_src1 : EX_div_src1;
   assign abs2      = src2_neg ? -EX_div_src2 : EX_div_src2;

   // Trial subtraction on the 33-bit shifted partial remainder; bit 32 is the borrow.
   assign diff      = {rem_q, quo_q[31]} - {1'b0, dvs_q};
   assign restore   = {rem_q[30:0], quo_q[31]};

   assign quo_fix   = neg_quo_q ? -quo_q : quo_q;
   assign rem_fix   = neg_rem_q ? -rem_q : rem_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stall_div = 1'b0;
      div_done  = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               stall_div = 1'b1;
               state_d   = (EX_div_src2 == 32'd0) ? StDone : StIter;
            end
         end
         StIter: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               stall_div = 1'b1;
               if (cnt_q == 6'd31) begin
                  state_d = StFix;
               end
            end
         end
         StFix: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               stall_div = 1'b1;
               state_d   = StDone;
            end
         end
         StDone: begin
            div_done = 1'b1;
            if (!stall_dcache) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q          <= 6'd0;
         quo_q          <= 32'd0;
         dvs_q          <= 32'd0;
         rem_q          <= 32'd0;
         neg_quo_q      <= 1'b0;
         neg_rem_q      <= 1'b0;
         rem_sel_q      <= 1'b0;
         MEM_div_result <= 32'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  cnt_q     <= 6'd0;
                  quo_q     <= abs1;
                  dvs_q     <= abs2;
                  rem_q     <= 32'd0;
                  neg_quo_q <= src1_neg ^ src2_neg;
                  neg_rem_q <= src1_neg;
                  rem_sel_q <= EX_div_op[1];
                  if (EX_div_src2 == 32'd0) begin
                     MEM_div_result <= EX_div_op[1] ? EX_div_src1 : 32'hFFFF_FFFF;
                  end
               end
            end
            StIter: begin
               if (!flush) begin
                  cnt_q <= cnt_q + 6'd1;
                  if (!diff[32]) begin
                     rem_q <= diff[31:0];
                     quo_q <= {quo_q[30:0], 1'b1};
                  end else begin
                     rem_q <= restore;
                     quo_q <= {quo_q[30:0], 1'b0};
                  end
               end
            end
            StFix: begin
               if (!flush) begin
                  MEM_div_result <= rem_sel_q ? rem_fix : quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
